uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_arbiter_if.sv | 41 ++++
 rtl/byte_fifo.sv | 56 +++++
 rtl/uart_tx_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit arbiter.
// Imported by the interface, the FIFO and the arbiter top.
package uart_pkg;

  localparam int DEPTH_DEF        = 4;
  localparam int BUSY_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_IDLE = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshakes plus the uart_tx side of the arbiter.
// slave is the arbiter view, master the driving environment.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          req0_valid;
  logic [7:0]    req0_byte;
  logic          req0_ready;
  logic          req1_valid;
  logic [7:0]    req1_byte;
  logic          req1_ready;
  logic [7:0]    tx_byte;
  logic          tx_en;
  logic          tx_ready;
  logic          busy;
  logic [LW-1:0] level0;
  logic [LW-1:0] level1;

  modport slave (
    input  req0_valid, req0_byte,
    input  req1_valid, req1_byte,
    input  tx_ready,
    output req0_ready, req1_ready,
    output tx_byte, tx_en, busy,
    output level0, level1
  );

  modport master (
    output req0_valid, req0_byte,
    output req1_valid, req1_byte,
    output tx_ready,
    input  req0_ready, req1_ready,
    input  tx_byte, tx_en, busy,
    input  level0, level1
  );

endinterface

// File: rtl/byte_fifo.sv
// Per-requester byte FIFO; power-of-two depth so pointers wrap freely.
// Pushes while full and pops while empty are ignored.
module byte_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full    = level_q == LW'(DEPTH);
  assign empty   = level_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rptr_q];
  assign level   = level_q;

  always_comb begin
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    level_d = level_q + LW'(do_push)
            - LW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single uart_tx.
// Grants from IDLE, pulses tx_en in ISSUE, then tracks uart busy.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [7:0]    byte_q, byte_d;

  logic [7:0] head0, head1;
  logic       full0, full1;
  logic       empty0, empty1;
  logic       pop0, pop1;
  logic       gnt1;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.req0_valid),
    .din   (bus.req0_byte),
    .pop   (pop0),
    .head  (head0),
    .level (bus.level0),
    .full  (full0),
    .empty (empty0)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.req1_valid),
    .din   (bus.req1_byte),
    .pop   (pop1),
    .head  (head1),
    .level (bus.level1),
    .full  (full1),
    .empty (empty1)
  );

  // On a tie, take req1 only if req0 was granted last.
  assign gnt1 = !empty1 && (empty0 || !last_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    byte_d  = byte_q;
    pop0    = 1'b0;
    pop1    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.tx_ready && !(empty0 && empty1)) begin
          pop0    = !gnt1;
          pop1    = gnt1;
          byte_d  = gnt1 ? head1 : head0;
          last_d  = gnt1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!bus.tx_ready) begin
          state_d = WAIT_IDLE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_IDLE: begin
        if (bus.tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      byte_q  <= byte_d;
    end
  end

  assign bus.tx_en      = state_q == ISSUE;
  assign bus.tx_byte    = byte_q;
  assign bus.req0_ready = !full0;
  assign bus.req1_ready = !full1;
  assign bus.busy       = (state_q != IDLE)
                       || !empty0 || !empty1;

endmodule
